// File: rtl/alu_pkg.sv
// Shared constants for the ALU result serial transmitter: FSM state
// encoding, default baud divisor and UART line levels.
package alu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // 50 MHz system clock, 9600 baud
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

endpackage

// File: rtl/alu_result_tx_baud_tick.sv
// Baud-rate divider: free-running counter with synchronous clear that
// pulses tick for one cycle when the count reaches CLKS_PER_BIT-1.
module baud_tick #(
  parameter int CLKS_PER_BIT = alu_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/alu_result_tx.sv
// Captures the signed ALU result on a rising edge of send and shifts it
// out LSB first on a UART line (start bit, size data bits, one stop bit).
module alu_result_tx
  import alu_pkg::*;
#(
  parameter int size         = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [size-1:0] result,
  input  logic                   send,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int BW = (size > 1) ? $clog2(size) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(size - 1);

  state_t            state_reg;
  state_t            state_next;
  logic              send_q_reg;
  logic [size-1:0]   shift_reg;
  logic [BW-1:0]     bit_idx_reg;
  logic              send_rise;
  logic              tick;
  logic              baud_clear;

  // send_q resets high so a button held through reset release is not an edge
  assign send_rise  = send & ~send_q_reg;
  assign baud_clear = (state_reg == ST_IDLE);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      send_q_reg  <= 1'b1;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
    end else begin
      send_q_reg <= send;
      if (state_reg == ST_IDLE && send_rise) begin
        shift_reg   <= result;
        bit_idx_reg <= '0;
      end else if (state_reg == ST_DATA && tick) begin
        shift_reg   <= shift_reg >> 1;
        bit_idx_reg <= (bit_idx_reg == LAST_BIT) ? '0 : bit_idx_reg + BW'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (send_rise) state_next = ST_START;
      ST_START: if (tick) state_next = ST_DATA;
      ST_DATA:  if (tick && bit_idx_reg == LAST_BIT) state_next = ST_STOP;
      ST_STOP:  if (tick) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx   = UART_IDLE;
    busy = (state_reg != ST_IDLE);
    done = 1'b0;
    case (state_reg)
      ST_START: tx = UART_START;
      ST_DATA:  tx = shift_reg[0];
      ST_STOP: begin
        tx   = UART_STOP;
        done = tick;
      end
      default:  tx = UART_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed bench for alu_result_tx with CLKS_PER_BIT=4, size=8: checks
// tx/busy/done every cycle against hand-derived frame waveforms.
module tb_alu_result_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] result;
  logic              send;
  logic              tx;
  logic              busy;
  logic              done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_result_tx #(
    .size(8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .result(result),
    .send  (send),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected line level for cycle i of a frame carrying v
  function automatic logic exp_tx(input logic [7:0] v, input int i);
    if (i < CPB) return 1'b0;
    if (i < 9 * CPB) return v[(i - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    send  = 1'b0;
    result = 8'sh00;
    repeat (3) step();
    total_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_hold: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0", tx, busy, done);
    else pass_cnt++;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL reset_idle cycle %0d: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0", i, tx, busy, done);
      else pass_cnt++;
    end
    $display("test_reset: idle after reset checked");
  endtask

  task automatic test_frame_a5();
    logic [7:0] v;
    v = 8'hA5;
    result = v;
    send = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      total_cnt++;
      if (tx !== exp_tx(v, i) || busy !== 1'b1 || done !== (i == FRAME - 1))
        $display("FAIL frame_a5 cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=%b",
                 i, tx, busy, done, exp_tx(v, i), (i == FRAME - 1));
      else pass_cnt++;
      if (i == 2) send = 1'b0;
    end
    step();
    total_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL frame_a5 end: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0", tx, busy, done);
    else pass_cnt++;
    $display("test_frame_a5: frame 0x%h checked", v);
  endtask

  task automatic test_held_send();
    logic [7:0] v;
    v = 8'hFD;
    result = -8'sd3;
    send = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic et, eb, ed;
      step();
      et = (i < FRAME) ? exp_tx(v, i) : 1'b1;
      eb = (i < FRAME);
      ed = (i == FRAME - 1);
      total_cnt++;
      if (tx !== et || busy !== eb || done !== ed)
        $display("FAIL held_send cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=%b done=%b",
                 i, tx, busy, done, et, eb, ed);
      else pass_cnt++;
    end
    send = 1'b0;
    step();
    $display("test_held_send: single frame 0x%h checked over 100 cycles", v);
  endtask

  task automatic test_ignored_rises();
    logic [7:0] v;
    v = 8'h3C;
    result = v;
    send = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      total_cnt++;
      if (tx !== exp_tx(v, i) || busy !== 1'b1 || done !== (i == FRAME - 1))
        $display("FAIL ignored_rises cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=%b",
                 i, tx, busy, done, exp_tx(v, i), (i == FRAME - 1));
      else pass_cnt++;
      if (i == 1)  send = 1'b0;
      if (i == 9)  send = 1'b1;
      if (i == 10) result = 8'sh00;
      if (i == 20) send = 1'b0;
      if (i == FRAME - 1) send = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      step();
      total_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL ignored_rises idle %0d: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0", i, tx, busy, done);
      else pass_cnt++;
    end
    send = 1'b0;
    step();
    $display("test_ignored_rises: frame 0x%h kept, mid-frame and done-cycle rises ignored", v);
  endtask

  task automatic test_mid_reset();
    logic [7:0] v;
    v = 8'h5A;
    result = v;
    send = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      total_cnt++;
      if (tx !== exp_tx(v, i) || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL mid_reset partial cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                 i, tx, busy, done, exp_tx(v, i));
      else pass_cnt++;
      if (i == 1)  send = 1'b0;
      if (i == 14) reset = 1'b1;
    end
    step();
    total_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_reset abort: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0", tx, busy, done);
    else pass_cnt++;
    reset = 1'b0;
    repeat (3) step();
    v = 8'hC3;
    result = v;
    send = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      total_cnt++;
      if (tx !== exp_tx(v, i) || busy !== 1'b1 || done !== (i == FRAME - 1))
        $display("FAIL mid_reset refresh cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=%b",
                 i, tx, busy, done, exp_tx(v, i), (i == FRAME - 1));
      else pass_cnt++;
      if (i == 1) send = 1'b0;
    end
    step();
    total_cnt++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL mid_reset refresh end: tx=%b busy=%b, expected tx=1 busy=0", tx, busy);
    else pass_cnt++;
    $display("test_mid_reset: abort then frame 0x%h checked", v);
  endtask

  task automatic test_send_through_reset();
    logic [7:0] v;
    v = 8'h81;
    result = v;
    send = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL send_through_reset idle %0d: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0", i, tx, busy, done);
      else pass_cnt++;
    end
    send = 1'b0;
    repeat (2) step();
    send = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      total_cnt++;
      if (tx !== exp_tx(v, i) || busy !== 1'b1 || done !== (i == FRAME - 1))
        $display("FAIL send_through_reset frame cycle %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=%b",
                 i, tx, busy, done, exp_tx(v, i), (i == FRAME - 1));
      else pass_cnt++;
      if (i == 1) send = 1'b0;
    end
    step();
    total_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL send_through_reset end: tx=%b busy=%b done=%b, expected tx=1 busy=0 done=0", tx, busy, done);
    else pass_cnt++;
    $display("test_send_through_reset: no frame on release, frame 0x%h on press", v);
  endtask

  initial begin
    reset  = 1'b1;
    send   = 1'b0;
    result = 8'sh00;
    test_reset();
    test_frame_a5();
    test_held_send();
    test_ignored_rises();
    test_mid_reset();
    test_send_through_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Serial transmitter for the ALU result. It captures the signed ALU output on a rising edge of a `send` request and shifts it out on a single UART line, framed as 8N1 when `size` = 8. It sits between the ALU result bus (the bus that also drives `leds`) and the board's serial TX pin, so results can be read on a host terminal instead of only on LEDs.

## Interface
- `size`, 8, width of the ALU result and number of data bits per frame.
- `CLKS_PER_BIT`, 5208, clock cycles per serial bit (50 MHz / 9600 baud). Must be ≥ 2.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `result`  input  signed [size-1:0]  ALU result, sampled only at frame start.
- `send`  input  1  transmit request (push-button level); acts on its rising edge only.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  high from frame start through the last stop-bit cycle.
- `done`  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, state=IDLE, internal `send_q`=1, counters=0. Holding `send` high through reset release does not start a frame.
- Edge detect: `send_rise = send & ~send_q`, with `send_q` registered every cycle.
- FSM states and transitions:
  - IDLE: `tx`=1. On `send_rise`, latch `result` into the shift register, clear the baud counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first, for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right and increment the index. After bit `size`-1, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. `done`=1 on the final cycle, then go to IDLE.
- `busy` = (state ≠ IDLE).
- The data bits are the raw two's-complement bits of `result`. No sign extension, no parity.
- Changes on `result` after frame start do not affect the frame in flight.
- `send_rise` while not in IDLE is ignored; there is no queueing. This includes the `done` cycle.
- `reset` asserted mid-frame: the next cycle has `tx`=1, `busy`=0, `done`=0 and state IDLE. The partial frame is abandoned.
- Bit counter width: `$clog2(size)`. Baud counter width: `$clog2(CLKS_PER_BIT)`. The baud counter wraps to 0 at CLKS_PER_BIT-1.

## Timing
- `send` rises before edge N, so `send_rise` is seen at edge N. From edge N: state=START, `tx`=0, `busy`=1 (registered outputs, 1-cycle latency).
- Start bit: edges N .. N+CLKS_PER_BIT-1.
- Data bit k: starts at edge N+(k+1)·CLKS_PER_BIT.
- Stop bit: starts at edge N+(size+1)·CLKS_PER_BIT.
- `done`=1 for the cycle following edge N+(size+2)·CLKS_PER_BIT-1.
- At the next edge after `done`: `busy`=0 and state=IDLE.
- Frame length: (size+2)·CLKS_PER_BIT cycles. The earliest next accepted edge is the cycle after `busy` falls.

## Structure
- Shared package `alu_pkg`:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP (2 bits);
  - default `CLKS_PER_BIT`;
  - UART idle/start/stop level constants.
- One natural sub-module: `baud_tick`. It is a counter with a synchronous clear and outputs a one-cycle `tick` when the count reaches CLKS_PER_BIT-1. The FSM advances only on `tick`.
- The edge detector, shift register and FSM live in `alu_result_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and size=8.
- Reset, then idle for 20 cycles → `tx`=1, `busy`=0, `done`=0 throughout.
- `result`=8'hA5, one `send` rise → `tx` = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. `busy` is high for exactly 40 cycles. `done` pulses once on the 40th cycle.
- `result`=-3 (8'hFD), `send` held high for 100 cycles → exactly one frame with data bits 1,0,1,1,1,1,1,1. No second frame starts.
- Second `send` rise at cycle 10 of a frame, and another on the `done` cycle, with `result` changed to 8'h00 mid-frame → both rises ignored. The frame still carries the original value.
- `reset` asserted at cycle 15 of a frame → next cycle `tx`=1, `busy`=0. A fresh `send` rise then produces a complete, correct frame.
- `send` held high across reset release → no frame. Release `send` and press again → one frame.
